// File: rtl/cdr_pkg.sv
// Shared types and constants for the CDR acquisition/lock controller.
package cdr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACQUIRE  = 3'd1,
    ST_VERIFY   = 3'd2,
    ST_LOCKED   = 3'd3,
    ST_HOLDOVER = 3'd4
  } cdr_state_e;

  localparam int CDR_W = 16;
  localparam int ERR_W = 8;

  // Error counters stick at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cdr_interval_classify.sv
// Combinational classification of one edge interval against the current
// bit-interval threshold: harmonic match (k=1..4), short, long or error.
module cdr_interval_classify #(
  parameter int W   = 16,
  parameter int TOL = 2
) (
  input  logic [W-1:0] interval,
  input  logic [W-1:0] thr,
  output logic         match,
  output logic [2:0]   k,
  output logic         too_short,
  output logic         too_long,
  output logic         error
);

  // Three extra bits hold 4*thr+TOL without overflow.
  localparam int XW = W + 3;

  logic [XW-1:0] iv_x, thr_x, mult, lo, hi;
  logic          all_ones;

  always_comb begin
    iv_x     = XW'(interval);
    thr_x    = XW'(thr);
    all_ones = &interval;
    match    = 1'b0;
    k        = 3'd0;
    mult     = '0;
    lo       = '0;
    hi       = '0;
    // Walk downward so the lowest overlapping harmonic is the one kept.
    for (int i = 4; i >= 1; i--) begin
      mult = thr_x * XW'(i);
      lo   = (mult >= XW'(TOL)) ? mult - XW'(TOL) : '0;
      hi   = mult + XW'(TOL);
      if (!all_ones && iv_x >= lo && iv_x <= hi) begin
        match = 1'b1;
        k     = 3'(i);
      end
    end
    too_short = (thr_x >= XW'(TOL)) && (iv_x < thr_x - XW'(TOL));
    too_long  = all_ones || (iv_x > (thr_x << 2) + XW'(TOL));
    error     = too_short || (!match && !too_long);
  end

endmodule

// File: rtl/cdr_lock_ctrl.sv
// Acquire/verify/lock/holdover sequencer for bit-clock recovery; owns the
// bit-interval threshold handed to the recovered-clock divider.
module cdr_lock_ctrl
  import cdr_pkg::*;
#(
  parameter int W          = CDR_W,
  parameter int THR_INIT   = 100,
  parameter int MIN_INT    = 2,
  parameter int TOL        = 2,
  parameter int ACQ_EDGES  = 64,
  parameter int LOCK_EDGES = 256,
  parameter int MAX_ERR    = 4,
  parameter int WIN_EDGES  = 1024,
  parameter int TIMEOUT    = 65535
) (
  input  logic             clk_200M,
  input  logic             rst,
  input  logic             enable,
  input  logic             edge_stb,
  input  logic [W-1:0]     interval,
  output logic [W-1:0]     thr_o,
  output logic             thr_load,
  output logic             locked,
  output logic [2:0]       state_o,
  output logic [ERR_W-1:0] err_count
);

  localparam int ACQ_CW  = $clog2(ACQ_EDGES + 1);
  localparam int LOCK_CW = $clog2(LOCK_EDGES + 1);
  localparam int WIN_CW  = $clog2(WIN_EDGES + 1);
  localparam int IDLE_CW = $clog2(TIMEOUT + 1);

  cdr_state_e         state_q, state_d;
  logic [W-1:0]       thr_q, thr_d, min_q, min_d;
  logic               thr_load_q, thr_load_d, locked_q;
  logic [ACQ_CW-1:0]  edge_cnt_q, edge_cnt_d;
  logic [LOCK_CW-1:0] ok_q, ok_d, ok_new;
  logic [ERR_W-1:0]   err_q, err_d, err_new;
  logic [WIN_CW-1:0]  win_q, win_d, win_new;
  logic [IDLE_CW-1:0] idle_q, idle_d;
  logic               discard_q, discard_d;

  logic       c_match, c_short, c_long, c_error;
  logic [2:0] c_k;

  cdr_interval_classify #(.W(W), .TOL(TOL)) u_classify (
    .interval (interval),
    .thr      (thr_q),
    .match    (c_match),
    .k        (c_k),
    .too_short(c_short),
    .too_long (c_long),
    .error    (c_error)
  );

  // Edge events shared by the next-state and datapath processes.
  logic         acc, acq_done, verify_fail, verify_lock, win_end, win_fail;
  logic         tighten, timeout, run_st;
  logic [W-1:0] iv_min;

  assign acc         = edge_stb && !discard_q && (interval >= W'(MIN_INT));
  assign iv_min      = (interval < min_q) ? interval : min_q;
  assign acq_done    = acc && (edge_cnt_q == ACQ_CW'(ACQ_EDGES - 1));
  assign err_new     = c_error ? err_sat_inc(err_q) : err_q;
  assign ok_new      = ok_q + LOCK_CW'(c_match);
  assign win_new     = win_q + 1'b1;
  assign verify_fail = acc && (err_new > ERR_W'(MAX_ERR));
  assign verify_lock = acc && (ok_new == LOCK_CW'(LOCK_EDGES));
  assign win_end     = acc && (win_new == WIN_CW'(WIN_EDGES));
  assign win_fail    = win_end && (err_new > ERR_W'(MAX_ERR));
  assign tighten     = acc && c_match && (c_k == 3'd1) && (interval < thr_q);
  assign run_st      = (state_q == ST_VERIFY) || (state_q == ST_LOCKED);
  assign timeout     = run_st && !edge_stb && (idle_q == IDLE_CW'(TIMEOUT));

  always_ff @(posedge clk_200M) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      thr_q      <= W'(THR_INIT);
      thr_load_q <= 1'b0;
      locked_q   <= 1'b0;
      min_q      <= '0;
      edge_cnt_q <= '0;
      ok_q       <= '0;
      err_q      <= '0;
      win_q      <= '0;
      idle_q     <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      thr_q      <= thr_d;
      thr_load_q <= thr_load_d;
      locked_q   <= (state_d == ST_LOCKED);
      min_q      <= min_d;
      edge_cnt_q <= edge_cnt_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      win_q      <= win_d;
      idle_q     <= idle_d;
      discard_q  <= discard_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = ST_ACQUIRE;
      ST_ACQUIRE:  if (acq_done) state_d = ST_VERIFY;
      ST_VERIFY: begin
        if (timeout)          state_d = ST_HOLDOVER;
        else if (verify_fail) state_d = ST_ACQUIRE;
        else if (verify_lock) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (timeout)       state_d = ST_HOLDOVER;
        else if (win_fail) state_d = ST_ACQUIRE;
      end
      ST_HOLDOVER: if (acc) state_d = ST_VERIFY;
      default:     state_d = ST_IDLE;
    endcase
    if (!enable) state_d = ST_IDLE;
  end

  always_comb begin
    thr_d      = thr_q;
    thr_load_d = 1'b0;
    min_d      = min_q;
    edge_cnt_d = edge_cnt_q;
    ok_d       = ok_q;
    err_d      = err_q;
    win_d      = win_q;
    discard_d  = discard_q && !edge_stb;
    idle_d     = (edge_stb || !run_st) ? '0 :
                 (idle_q == IDLE_CW'(TIMEOUT)) ? idle_q : idle_q + 1'b1;

    case (state_q)
      ST_ACQUIRE: if (acc) begin
        min_d      = iv_min;
        edge_cnt_d = edge_cnt_q + 1'b1;
        if (acq_done) begin
          thr_d      = iv_min;
          thr_load_d = 1'b1;
        end
      end
      ST_VERIFY: if (acc) begin
        ok_d  = ok_new;
        err_d = err_new;
      end
      ST_LOCKED: if (acc) begin
        win_d = win_new;
        err_d = err_new;
        if (win_end && !win_fail) begin
          win_d = '0;
          err_d = '0;
        end
        // A failing window exit suppresses any tightening on that edge.
        if (tighten && !win_fail) begin
          thr_d      = interval;
          thr_load_d = 1'b1;
        end
      end
      // Resuming edge is scored against freshly cleared counters.
      ST_HOLDOVER: if (acc) begin
        ok_d  = LOCK_CW'(c_match);
        err_d = ERR_W'(c_error);
      end
      default: ;
    endcase

    if (state_d != state_q) begin
      case (state_d)
        ST_ACQUIRE: begin
          min_d      = '1;
          edge_cnt_d = '0;
          discard_d  = 1'b1;
        end
        ST_VERIFY: if (state_q == ST_ACQUIRE) begin
          ok_d  = '0;
          err_d = '0;
        end
        ST_LOCKED: begin
          win_d = '0;
          err_d = '0;
        end
        ST_HOLDOVER: discard_d = 1'b1;
        default: ;
      endcase
    end

    if (state_d != ST_VERIFY && state_d != ST_LOCKED) idle_d = '0;

    if (state_d == ST_IDLE) begin
      thr_d      = thr_q;
      thr_load_d = 1'b0;
      edge_cnt_d = '0;
      ok_d       = '0;
      err_d      = '0;
      win_d      = '0;
      discard_d  = 1'b0;
    end
  end

  assign thr_o     = thr_q;
  assign thr_load  = thr_load_q;
  assign locked    = locked_q;
  assign state_o   = state_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// Directed bench for cdr_lock_ctrl: a classification vector table in VERIFY
// plus hand-written lock, holdover, window and reset/enable sequences.
module tb_cdr_lock_ctrl;
  localparam int W = 16;

  logic         clk_200M = 1'b0;
  logic         rst = 1'b1, enable = 1'b0, edge_stb = 1'b0;
  logic [W-1:0] interval = '0;
  logic [W-1:0] thr_o;
  logic         thr_load, locked;
  logic [2:0]   state_o;
  logic [7:0]   err_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_200M = ~clk_200M;

  cdr_lock_ctrl dut (
    .clk_200M (clk_200M),
    .rst      (rst),
    .enable   (enable),
    .edge_stb (edge_stb),
    .interval (interval),
    .thr_o    (thr_o),
    .thr_load (thr_load),
    .locked   (locked),
    .state_o  (state_o),
    .err_count(err_count)
  );

  typedef struct {
    logic         stb;
    logic [W-1:0] iv;
    logic [2:0]   st;
    logic [7:0]   err;
  } vec_t;

  vec_t tbl[15];

  task automatic tick();
    @(posedge clk_200M);
    #1;
  endtask

  task automatic edge_in(input logic [W-1:0] iv);
    edge_stb = 1'b1;
    interval = iv;
    tick();
    edge_stb = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Leaves the DUT freshly in ACQUIRE with the discard pending.
  task automatic restart();
    rst = 1'b1; enable = 1'b0; edge_stb = 1'b0;
    tick(); tick();
    rst = 1'b0; enable = 1'b1;
    tick();
  endtask

  task automatic lock40();
    restart();
    repeat (65) edge_in(16'd40);
    repeat (256) edge_in(16'd40);
  endtask

  initial begin
    logic [W-1:0] nrz[8];
    bit           seen;
    nrz = '{16'd40, 16'd80, 16'd120, 16'd160, 16'd41, 16'd79, 16'd121, 16'd159};

    // Expected classification at thr=40, starting from VERIFY with err=0.
    tbl[0]  = '{1'b1, 16'd41,    3'd2, 8'd0};
    tbl[1]  = '{1'b1, 16'd79,    3'd2, 8'd0};
    tbl[2]  = '{1'b1, 16'd121,   3'd2, 8'd0};
    tbl[3]  = '{1'b1, 16'd162,   3'd2, 8'd0};
    tbl[4]  = '{1'b1, 16'd200,   3'd2, 8'd0};
    tbl[5]  = '{1'b1, 16'hFFFF,  3'd2, 8'd0};
    tbl[6]  = '{1'b1, 16'd1,     3'd2, 8'd0};
    tbl[7]  = '{1'b1, 16'd57,    3'd2, 8'd1};
    tbl[8]  = '{1'b1, 16'd30,    3'd2, 8'd2};
    tbl[9]  = '{1'b0, 16'd0,     3'd2, 8'd2};
    tbl[10] = '{1'b1, 16'd100,   3'd2, 8'd3};
    tbl[11] = '{1'b1, 16'd163,   3'd2, 8'd3};
    tbl[12] = '{1'b1, 16'd37,    3'd2, 8'd4};
    tbl[13] = '{1'b1, 16'd38,    3'd2, 8'd4};
    tbl[14] = '{1'b1, 16'd57,    3'd1, 8'd5};

    tick(); tick();
    chk("rst state", 32'(state_o), 0);
    chk("rst thr", 32'(thr_o), 100);
    chk("rst load", 32'(thr_load), 0);
    chk("rst locked", 32'(locked), 0);
    chk("rst err", 32'(err_count), 0);
    rst = 1'b0;
    tick();
    chk("idle hold", 32'(state_o), 0);

    // Clean lock at 40.
    enable = 1'b1;
    tick();
    chk("acq entry", 32'(state_o), 1);
    repeat (64) edge_in(16'd40);
    chk("acq 64 state", 32'(state_o), 1);
    chk("acq 64 thr", 32'(thr_o), 100);
    chk("acq 64 load", 32'(thr_load), 0);
    edge_in(16'd40);
    chk("acq done thr", 32'(thr_o), 40);
    chk("acq done load", 32'(thr_load), 1);
    chk("acq done state", 32'(state_o), 2);
    tick();
    chk("load pulse end", 32'(thr_load), 0);
    repeat (255) edge_in(16'd40);
    chk("verify 255 state", 32'(state_o), 2);
    chk("verify 255 locked", 32'(locked), 0);
    edge_in(16'd40);
    chk("lock state", 32'(state_o), 3);
    chk("lock locked", 32'(locked), 1);
    chk("lock err", 32'(err_count), 0);

    // Classification table in VERIFY.
    restart();
    repeat (65) edge_in(16'd40);
    chk("tbl setup", 32'(state_o), 2);
    for (int i = 0; i < 15; i++) begin
      edge_stb = tbl[i].stb;
      interval = tbl[i].iv;
      tick();
      edge_stb = 1'b0;
      chk($sformatf("tbl%0d state", i), 32'(state_o), 32'(tbl[i].st));
      chk($sformatf("tbl%0d err", i), 32'(err_count), 32'(tbl[i].err));
      chk($sformatf("tbl%0d thr", i), 32'(thr_o), 40);
    end

    // NRZ run lengths; first accepted edge is 40, discarded edge is 160.
    restart();
    edge_in(16'd160);
    edge_in(16'd40);
    repeat (63) edge_in(nrz[$urandom_range(0, 7)]);
    chk("nrz thr", 32'(thr_o), 40);
    chk("nrz state", 32'(state_o), 2);
    repeat (256) edge_in(nrz[$urandom_range(0, 7)]);
    chk("nrz lock", 32'(state_o), 3);

    // Reset while locked.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst state", 32'(state_o), 0);
    chk("mid rst thr", 32'(thr_o), 100);
    chk("mid rst locked", 32'(locked), 0);

    // Tightening, then a failing window closed by a would-be tightening edge.
    lock40();
    edge_in(16'd39);
    chk("tighten thr", 32'(thr_o), 39);
    chk("tighten load", 32'(thr_load), 1);
    repeat (5) edge_in(16'd57);
    chk("win err", 32'(err_count), 5);
    chk("win no early exit", 32'(state_o), 3);
    repeat (1017) edge_in(16'd39);
    chk("win 1023 state", 32'(state_o), 3);
    edge_in(16'd38);
    chk("win exit state", 32'(state_o), 1);
    chk("win exit thr", 32'(thr_o), 39);
    chk("win exit load", 32'(thr_load), 0);

    // enable low coincident with the acquisition-completing edge.
    repeat (64) edge_in(16'd20);
    chk("acq2 pre state", 32'(state_o), 1);
    enable = 1'b0;
    edge_in(16'd20);
    chk("en low state", 32'(state_o), 0);
    chk("en low thr", 32'(thr_o), 39);
    chk("en low load", 32'(thr_load), 0);

    // Timeout into holdover and resume.
    lock40();
    repeat (65000) tick();
    chk("pre timeout", 32'(state_o), 3);
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      tick();
      if (state_o == 3'd4) seen = 1'b1;
    end
    chk("holdover reached", 32'(seen), 1);
    chk("holdover locked", 32'(locked), 0);
    chk("holdover thr", 32'(thr_o), 40);
    edge_in(16'd40);
    chk("holdover discard", 32'(state_o), 4);
    chk("holdover no load", 32'(thr_load), 0);
    edge_in(16'd40);
    chk("resume verify", 32'(state_o), 2);
    repeat (254) edge_in(16'd40);
    chk("resume 254", 32'(state_o), 2);
    repeat (2) edge_in(16'd40);
    chk("relock", 32'(state_o), 3);
    chk("relock locked", 32'(locked), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdr_lock_ctrl.md
# cdr_lock_ctrl

- Acquisition and lock controller for the bit-clock recovery path, running on the 200 MHz base clock.
- Consumes per-edge interval measurements from the edge detector: a strobe plus the clk_200M cycle count since the previous data edge.
- Sequences acquire, verify, lock and holdover.
- Drives the bit-interval threshold that the recovered-clock divider consumes, and reports lock status and the error count.

## Interface
- W, 16: width of interval and threshold
- THR_INIT, 100: thr_o value after reset
- MIN_INT, 2: intervals below this are glitches; ignored entirely
- TOL, 2: ± tolerance in cycles for harmonic match
- ACQ_EDGES, 64: edges sampled for the minimum search
- LOCK_EDGES, 256: matching edges required in VERIFY
- MAX_ERR, 4: error limit per verify run or lock window
- WIN_EDGES, 1024: edges per LOCKED error window
- TIMEOUT, 65535: idle cycles without edge_stb before HOLDOVER
- clk_200M  input  1  base clock; everything is synchronous to its rising edge
- rst  input  1  synchronous, active-high reset
- enable  input  1  run request; level
- edge_stb  input  1  one-cycle pulse per data edge
- interval  input  W  cycles since previous edge; valid with edge_stb; all-ones means saturated
- thr_o  output  W  bit-interval threshold to clock generator
- thr_load  output  1  one-cycle pulse in the cycle thr_o takes a new value
- locked  output  1  high only in LOCKED
- state_o  output  3  encoding: IDLE=0, ACQUIRE=1, VERIFY=2, LOCKED=3, HOLDOVER=4
- err_count  output  8  current-run/window error count, saturating at 255

## Operation
- Reset values: state IDLE, thr_o=THR_INIT, thr_load=0, locked=0, err_count=0; all internal counters are 0.
- enable=0 in any state → IDLE next cycle. thr_o holds its value; counters clear.
- IDLE: when enable=1 → ACQUIRE. Entry sets min_reg to all-ones.
- Discard rule: the first edge_stb after entering ACQUIRE or HOLDOVER is discarded, because its interval spans the state entry.
- ACQUIRE:
  - Each accepted edge with interval≥MIN_INT: min_reg=min(min_reg, interval), edge_cnt++.
  - When edge_cnt reaches ACQ_EDGES: thr_o←min_reg, thr_load pulse, → VERIFY, ok_cnt=err_cnt=0.
- Classification of an edge against thr, for k=1..4:
  - match(k) if |interval−k·thr|≤TOL.
  - short if interval<thr−TOL.
  - long if interval>4·thr+TOL or interval is all-ones.
  - Otherwise error. short also counts as an error.
  - Multiples are computed at W+3 bits. The lower bound saturates at 0. The lowest k wins when windows overlap.
- VERIFY:
  - match → ok_cnt++. error → err_cnt++. long → neutral.
  - err_cnt>MAX_ERR → ACQUIRE. ok_cnt==LOCK_EDGES → LOCKED, window counters cleared.
- LOCKED:
  - Every accepted edge advances win_cnt; errors increment err_cnt.
  - Tightening: if match(1) and interval<thr_o, then thr_o←interval with thr_load.
  - When win_cnt reaches WIN_EDGES: if err_cnt≤MAX_ERR, clear win_cnt and err_cnt; else → ACQUIRE.
  - Exceeding MAX_ERR before window end does not exit early.
- Timeout: idle_cnt counts cycles without edge_stb. In VERIFY or LOCKED, idle_cnt==TIMEOUT → HOLDOVER. thr_o is held and locked drops.
- HOLDOVER: the first edge is discarded. The next accepted edge is classified, and the controller → VERIFY with counters cleared beforehand.
- Simultaneous events:
  - enable low beats everything.
  - edge_stb in the timeout cycle wins and resets idle_cnt.
  - An error on the window-closing edge is counted before evaluation.
  - Tightening and window exit on the same edge: exit wins and thr_o is not updated.
- rst mid-operation behaves exactly as a reset from power-up; the controller restarts from IDLE.

## Timing
- All outputs are registered. edge_stb at cycle n → state_o, thr_o, thr_load, locked and err_count reflect that edge at cycle n+1.
- thr_load is high exactly one cycle per thr_o change. It is never asserted in IDLE or HOLDOVER.
- locked rises in the same cycle state_o becomes 3, and falls in the same cycle state_o leaves 3.
- No back-to-back edge_stb restriction; one edge is processed per cycle.

## Structure
- Package cdr_pkg: state enum and its 3-bit encoding, default W, the err_count width constant.
- Sub-module cdr_interval_classify: purely combinational. Inputs interval and thr. Outputs match, k, short, long, error. Instantiated once.
- FSM and counters live in cdr_lock_ctrl.

## Test plan
- Clean lock: enable; edge_stb every 40 cycles with interval=40 → thr_o=40 and a thr_load pulse after the 65th edge (first edge discarded); locked=1 after 256 further edges.
- NRZ runs: intervals randomly 40/80/120/160, at least one 40 in the first 64 edges → same thr_o=40 and lock. Intervals of 41/79 also match at TOL=2.
- Error exit: in VERIFY with thr=40, inject 5 intervals of 57 → err_count=5, state_o=1 the next cycle. Glitch intervals of 1 are ignored (err_count unchanged).
- Timeout/holdover: locked at 40, stop edges for 65535 cycles → state_o=4, locked=0, thr_o=40. Resume at 40 → VERIFY after the second edge, LOCKED after 256 more edges.
- Tightening and window: locked at 40, apply interval 39 → thr_o=39 with thr_load next cycle. Apply 5 interval-57 errors inside one 1024-edge window → ACQUIRE at window end, not earlier.
- Reset/enable: assert rst in LOCKED → state_o=0, thr_o=100, locked=0 next cycle. enable low during ACQUIRE coincident with edge_stb → IDLE, thr_o unchanged.
